// File: rtl/idma_obi_write_issuer.sv
// rtl/idma_obi_write_issuer.sv - OBI write-request issuer for legalized iDMA write bursts
// Optional feature macro: IDMA_OBI_WRITE_ERR_EN (sticky error reported with done_valid_o).
module idma_obi_write_issuer #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned OffsetWidth   = $clog2(StrbWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [AddrWidth-1:0]   w_addr_i,
    input  logic [OffsetWidth-1:0] w_offset_i,
    input  logic [OffsetWidth-1:0] w_tailer_i,
    input  logic                   w_last_i,
    input  logic [DataWidth-1:0]   buf_data_i,
    input  logic                   buf_valid_i,
    output logic                   buf_ready_o,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [StrbWidth-1:0]   obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic                   obi_err_i,
    output logic                   done_valid_o,
    output logic                   done_err_o,
    output logic                   busy_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        REQ       = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [StrbWidth-1:0]    be_q, be_d;
    logic                    last_q, last_d;
    logic [DataWidth-1:0]    data_q, data_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrWidth-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]     rd_ptr_q, rd_ptr_d;
    logic                    done_valid_q, done_valid_d;
    logic [StrbWidth-1:0]    be_calc;
    logic                    push, pop;

    // Byte enables from the first valid byte and the exclusive end byte (0 = up to the word end).
    always_comb begin
        be_calc = '0;
        for (int unsigned i = 0; i < StrbWidth; i++) begin
            be_calc[i] = (OffsetWidth'(i) >= w_offset_i) &&
                         ((w_tailer_i == '0) || (OffsetWidth'(i) < w_tailer_i));
        end
    end

    // Request FSM: accept a write request, collect its data, then hold the OBI request until granted.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        be_d        = be_q;
        last_d      = last_q;
        data_d      = data_q;
        w_ready_o   = 1'b0;
        buf_ready_o = 1'b0;
        obi_req_o   = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset gating keeps the handshakes quiet while rst_ni is held low.
                if (rst_ni && (cnt_q < MaxCnt)) begin
                    w_ready_o   = 1'b1;
                    buf_ready_o = w_valid_i;
                    if (w_valid_i) begin
                        addr_d  = w_addr_i;
                        be_d    = be_calc;
                        last_d  = w_last_i;
                        state_d = WAIT_DATA;
                        if (buf_valid_i) begin
                            data_d  = buf_data_i;
                            state_d = REQ;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                buf_ready_o = 1'b1;
                if (buf_valid_i) begin
                    data_d  = buf_data_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                obi_req_o = 1'b1;
                if (obi_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push = obi_req_o && obi_gnt_i;
    // A response with nothing outstanding has no matching request and is dropped.
    assign pop  = obi_rvalid_i && (cnt_q != '0);

    // Outstanding counter and in-order FIFO of last flags for granted writes.
    always_comb begin
        cnt_d    = cnt_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({push, pop})
            2'b10:   if (cnt_q != MaxCnt) cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (push) begin
            fifo_d[wr_ptr_q] = last_q;
            wr_ptr_d         = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        done_valid_d = pop && fifo_q[rd_ptr_q];
    end

    // State, request latches and response bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            be_q         <= '0;
            last_q       <= 1'b0;
            data_q       <= '0;
            cnt_q        <= '0;
            fifo_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            last_q       <= last_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            done_valid_q <= done_valid_d;
        end
    end

`ifdef IDMA_OBI_WRITE_ERR_EN
    logic err_q, err_d;
    logic done_err_q, done_err_d;
    logic err_acc;

    // Accumulate response errors over a transfer; report and clear them with its done pulse.
    always_comb begin
        err_d      = err_q;
        done_err_d = 1'b0;
        err_acc    = err_q | obi_err_i;
        if (pop) begin
            if (done_valid_d) begin
                done_err_d = err_acc;
                err_d      = 1'b0;
            end else begin
                err_d = err_acc;
            end
        end
    end

    // Sticky error and registered done error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            done_err_q <= done_err_d;
        end
    end

    assign done_err_o = done_err_q;
`else
    logic unused_err;
    assign unused_err = obi_err_i;
    assign done_err_o = 1'b0;
`endif

    assign obi_addr_o   = addr_q;
    assign obi_be_o     = be_q;
    assign obi_wdata_o  = data_q;
    assign obi_we_o     = 1'b1;
    assign done_valid_o = done_valid_q;
    assign busy_o       = (state_q != IDLE) || (cnt_q != '0);

    // A response while nothing is outstanding indicates a broken OBI slave.
    assert property (@(posedge clk_i) disable iff (!rst_ni) obi_rvalid_i |-> (cnt_q != '0));

endmodule

// File: doc/idma_obi_write_issuer.md
IDMA_OBI_WRITE_ISSUER -- requirements
Module: idma_obi_write_issuer

Interface
REQ-001 SHALL have parameter DataWidth, default 32: OBI data width in bits; a power of two, at least 16.
REQ-002 SHALL have parameter AddrWidth, default 32: byte-address width.
REQ-003 SHALL have parameter MaxOutstanding, default 2: granted writes awaiting response; at least 1.
REQ-004 SHALL derive StrbWidth = DataWidth/8 and OffsetWidth = clog2(StrbWidth).
REQ-005 SHALL have clk_i  in  1  single clock, all logic on its rising edge.
REQ-006 SHALL have rst_ni  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have w_valid_i / w_ready_o  in/out  1  legalized write-request handshake.
REQ-008 SHALL have w_addr_i  in  AddrWidth  word-aligned destination address.
REQ-009 SHALL have w_offset_i, w_tailer_i  in  OffsetWidth  first valid byte; end byte (exclusive, mod StrbWidth).
REQ-010 SHALL have w_last_i  in  1  request is the final one of its 1D transfer.
REQ-011 SHALL have buf_data_i  in  DataWidth  shifted write data.
REQ-012 SHALL have buf_valid_i / buf_ready_o  in/out  1  write-data handshake from the dataflow buffer.
REQ-013 SHALL have obi_req_o  out 1; obi_gnt_i  in 1; obi_addr_o  out AddrWidth; obi_we_o  out 1; obi_be_o  out StrbWidth; obi_wdata_o  out DataWidth.
REQ-014 SHALL have obi_rvalid_i  in 1  and obi_err_i  in 1: OBI response channel.
REQ-015 SHALL have done_valid_o  out 1, done_err_o  out 1, busy_o  out 1: transfer completion, error and activity.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT_DATA and REQ.
- IDLE: w_ready_o = 1 only when outstanding < MaxOutstanding.
- On the w handshake, SHALL latch addr, be and last, then go to WAIT_DATA.
- If buf_valid_i is also high in that cycle, SHALL latch the data too and go directly to REQ.
REQ-017 WAIT_DATA: buf_ready_o = 1; on the buf handshake SHALL latch the data and go to REQ.
REQ-018 REQ: obi_req_o = 1; addr, be, wdata and we SHALL be held stable from the latches until obi_gnt_i.
- On gnt, SHALL return to IDLE.
REQ-019 obi_be_o[i] SHALL be 1 iff i >= offset and (tailer == 0 or i < tailer); offset = tailer = 0 gives all ones.
REQ-020 obi_we_o SHALL be constant 1; buf_ready_o SHALL be 0 in REQ.
REQ-021 Outstanding counter (width clog2(MaxOutstanding+1)):
- +1 on req & gnt, -1 on rvalid, unchanged when both occur in the same cycle.
- SHALL never wrap.
- rvalid with counter 0 SHALL be ignored and flagged by assertion.
REQ-022 SHALL keep a FIFO of MaxOutstanding last flags: push on gnt, pop on rvalid; simultaneous push and pop allowed.
REQ-023 done_valid_o SHALL pulse exactly one cycle, registered, the cycle after an rvalid whose popped flag is 1.
REQ-024 busy_o SHALL be 1 when the state is not IDLE or outstanding != 0.
REQ-025 Latency: with buf_valid_i high and gnt held 1, w handshake to obi_req_o = 1 cycle; back-to-back throughput = 1 request per 2 cycles.

Reset
REQ-026 On rst_ni low, SHALL asynchronously go to IDLE and clear the counter, FIFO, latches and sticky error.
REQ-027 Outputs in reset SHALL be: obi_req_o=0, obi_be_o=0, obi_addr_o=0, obi_wdata_o=0, w_ready_o=0, buf_ready_o=0, done_valid_o=0, done_err_o=0, busy_o=0.
REQ-028 Reset asserted mid-transaction SHALL abandon outstanding responses; no done pulse is generated for them.

Configuration
REQ-029 Macro IDMA_OBI_WRITE_ERR_EN:
- Defined: a sticky error register SHALL OR obi_err_i on each rvalid.
- done_err_o SHALL equal the sticky value with done_valid_o, and the register SHALL clear on that pulse.
- Undefined: obi_err_i is ignored and done_err_o is tied 0.

Verification
REQ-030 Single request, addr 0x100, offset 1, tailer 3, last=1, data 0xAABBCCDD, gnt immediate, rvalid 2 cycles later -> be=0b0110, addr=0x100, one done_valid_o pulse, done_err_o=0.
REQ-031 Four requests, gnt held low 5 cycles, no rvalid -> req and addr stable throughout; w_ready_o=0 once outstanding=2.
REQ-032 Same-cycle gnt and rvalid with outstanding=1 -> outstanding stays 1, w_ready_o stays 1.
REQ-033 Three requests with last=0,0,1, rvalids in order -> exactly one done pulse, after the third rvalid.
REQ-034 With ERR_EN, err on the 2nd of 3 rvalids -> done_err_o=1 on the pulse; the next transfer reports 0. Without ERR_EN -> 0.
REQ-035 Reset asserted with outstanding=2 and the FSM in REQ -> all outputs at reset values next cycle; later rvalids produce no done pulse.
